// File: rtl/logic_sweep_pkg.sv
// Shared types and width helper for the exhaustive logic sweep checker.
package logic_sweep_pkg;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } sweep_state_e;

   // Bits needed to count 0..n-1, never less than one.
   function automatic int unsigned clog2_min1(input int unsigned n);
      int unsigned w;
      w = 1;
      while ((32'd1 << w) < n) w = w + 1;
      return w;
   endfunction

endpackage

// File: rtl/logic_sweep_checker_dwell_timer.sv
// Dwell counter: counts 0..DWELL-1 while enabled and flags the last cycle of each window.
module dwell_timer
   import logic_sweep_pkg::*;
#(
   parameter int unsigned DWELL = 10
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clear,
   input  logic en,
   output logic tick
);

   localparam int unsigned   CW   = clog2_min1(DWELL);
   localparam logic [CW-1:0] LAST = CW'(DWELL - 1);

   logic [CW-1:0] cnt_q, cnt_d;

   assign tick = en && (cnt_q == LAST);

   always_comb begin
      cnt_d = cnt_q;
      if (clear) begin
         cnt_d = '0;
      end else if (en) begin
         cnt_d = tick ? '0 : cnt_q + CW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/logic_sweep_checker.sv
// Walks every N_IN-bit input vector, holds each for DWELL cycles and scores the
// DUT output sampled at the end of each dwell against a truth table latched at start.
module logic_sweep_checker
   import logic_sweep_pkg::*;
#(
   parameter int unsigned N_IN  = 3,
   parameter int unsigned DWELL = 10
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   start,
   input  logic                   abort,
   input  logic [(1<<N_IN)-1:0]   expected,
   input  logic                   y_in,
   output logic [N_IN-1:0]        vec_out,
   output logic                   busy,
   output logic                   done,
   output logic                   pass,
   output logic [N_IN:0]          fail_cnt,
   output logic [N_IN-1:0]        first_fail_idx,
   output logic                   fail_seen
);

   localparam int unsigned     NV       = 1 << N_IN;
   localparam logic [N_IN-1:0] LAST_VEC = '1;

   sweep_state_e    state_q, state_d;
   logic [NV-1:0]   exp_q, exp_d;
   logic [N_IN-1:0] vec_q, vec_d;
   logic [N_IN:0]   cnt_q, cnt_d;
   logic [N_IN-1:0] ffi_q, ffi_d;
   logic            seen_q, seen_d;
   logic            busy_q, busy_d;
   logic            done_q, done_d;
   logic            pass_q, pass_d;
   logic            start_ok;
   logic            tick;

   assign start_ok = start && (state_q != RUN);

   dwell_timer #(
      .DWELL (DWELL)
   ) u_timer (
      .clk   (clk),
      .rst_n (rst_n),
      .clear (start_ok),
      .en    (state_q == RUN),
      .tick  (tick)
   );

   always_comb begin
      state_d = state_q;
      exp_d   = exp_q;
      vec_d   = vec_q;
      cnt_d   = cnt_q;
      ffi_d   = ffi_q;
      seen_d  = seen_q;
      busy_d  = busy_q;
      done_d  = done_q;
      unique case (state_q)
         IDLE, DONE: begin
            if (start) begin
               state_d = RUN;
               exp_d   = expected;
               vec_d   = '0;
               cnt_d   = '0;
               ffi_d   = '0;
               seen_d  = 1'b0;
               busy_d  = 1'b1;
               done_d  = 1'b0;
            end
         end
         RUN: begin
            // Abort wins over a coinciding sample, so that sample is simply dropped.
            if (abort) begin
               state_d = IDLE;
               busy_d  = 1'b0;
            end else if (tick) begin
               if (y_in != exp_q[vec_q]) begin
                  cnt_d = cnt_q + (N_IN+1)'(1);
                  if (!seen_q) begin
                     seen_d = 1'b1;
                     ffi_d  = vec_q;
                  end
               end
               if (vec_q == LAST_VEC) begin
                  state_d = DONE;
                  busy_d  = 1'b0;
                  done_d  = 1'b1;
               end else begin
                  vec_d = vec_q + N_IN'(1);
               end
            end
         end
         default: begin
            state_d = IDLE;
            busy_d  = 1'b0;
         end
      endcase
      pass_d = done_d && (cnt_d == '0);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         exp_q   <= '0;
         vec_q   <= '0;
         cnt_q   <= '0;
         ffi_q   <= '0;
         seen_q  <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         pass_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         exp_q   <= exp_d;
         vec_q   <= vec_d;
         cnt_q   <= cnt_d;
         ffi_q   <= ffi_d;
         seen_q  <= seen_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         pass_q  <= pass_d;
      end
   end

   assign vec_out        = vec_q;
   assign busy           = busy_q;
   assign done           = done_q;
   assign pass           = pass_q;
   assign fail_cnt       = cnt_q;
   assign first_fail_idx = ffi_q;
   assign fail_seen      = seen_q;

endmodule

// File: tb/tb_logic_sweep_checker.sv
// Directed bench: a 3-input majority sweep (DWELL=10) and a 1-input, 1-cycle-dwell sweep.
module tb_logic_sweep_checker;

   localparam logic [7:0] EXP_TBL = 8'b1110_1000;

   logic       clk;
   logic       rst_n;
   logic       start, abort, stuck0;
   logic [7:0] exp_in;
   logic       y_in;
   logic [2:0] vec_out;
   logic       busy, done, pass, fail_seen;
   logic [3:0] fail_cnt;
   logic [2:0] first_fail_idx;

   logic       start_b, stuck_b, y_in_b;
   logic [1:0] expected_b;
   logic [0:0] vec_out_b;
   logic       busy_b, done_b, pass_b, fail_seen_b;
   logic [1:0] fail_cnt_b;
   logic [0:0] first_fail_idx_b;

   int vectors;
   int miscompares;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic maj(input logic [2:0] x);
      return (x[0] & x[1]) | (x[0] & x[2]) | (x[1] & x[2]);
   endfunction

   always_comb y_in   = stuck0  ? 1'b0 : maj(vec_out);
   always_comb y_in_b = stuck_b ? 1'b0 : vec_out_b[0];

   logic_sweep_checker #(.N_IN(3), .DWELL(10)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .start          (start),
      .abort          (abort),
      .expected       (exp_in),
      .y_in           (y_in),
      .vec_out        (vec_out),
      .busy           (busy),
      .done           (done),
      .pass           (pass),
      .fail_cnt       (fail_cnt),
      .first_fail_idx (first_fail_idx),
      .fail_seen      (fail_seen)
   );

   logic_sweep_checker #(.N_IN(1), .DWELL(1)) dut_b (
      .clk            (clk),
      .rst_n          (rst_n),
      .start          (start_b),
      .abort          (1'b0),
      .expected       (expected_b),
      .y_in           (y_in_b),
      .vec_out        (vec_out_b),
      .busy           (busy_b),
      .done           (done_b),
      .pass           (pass_b),
      .fail_cnt       (fail_cnt_b),
      .first_fail_idx (first_fail_idx_b),
      .fail_seen      (fail_seen_b)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      vectors++;
      assert (obs === expv) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   // Results expected from samples taken strictly before negedge index k of the sweep.
   task automatic model(input logic stuck, input int k, output int cnt, output int seen, output int first);
      logic [7:0] t;
      logic       y;
      t = EXP_TBL;
      cnt = 0; seen = 0; first = 0;
      for (int i = 0; i < 8; i++) begin
         if (10 * i + 9 < k) begin
            y = stuck ? 1'b0 : maj(3'(i));
            if (y != t[i]) begin
               cnt++;
               if (seen == 0) begin
                  seen  = 1;
                  first = i;
               end
            end
         end
      end
   endtask

   task automatic check_reset_vals(input string where);
      check({where, "_vec"},   vec_out, 0);
      check({where, "_busy"},  busy, 0);
      check({where, "_done"},  done, 0);
      check({where, "_pass"},  pass, 0);
      check({where, "_fcnt"},  fail_cnt, 0);
      check({where, "_fseen"}, fail_seen, 0);
      check({where, "_ffi"},   first_fail_idx, 0);
   endtask

   task automatic sweep(input logic stuck, input int abort_at, input int rst_at, input logic noisy);
      int exp_vec[$];
      int v, fcnt, fseen, ffirst;
      stuck0 = stuck;
      for (int k = 0; k < 80; k++) exp_vec.push_back(k / 10);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int k = 0; k < 80; k++) begin
         v = exp_vec.pop_front();
         check("vec_out", vec_out, v);
         check("busy_run", busy, 1);
         check("done_run", done, 0);
         if (k == 0) begin
            check("clr_fcnt", fail_cnt, 0);
            check("clr_fseen", fail_seen, 0);
            check("clr_ffi", first_fail_idx, 0);
         end
         if (k == abort_at) begin
            abort = 1'b1;
            @(negedge clk);
            abort = 1'b0;
            model(stuck, k, fcnt, fseen, ffirst);
            check("abort_busy", busy, 0);
            check("abort_done", done, 0);
            check("abort_pass", pass, 0);
            check("abort_vec", vec_out, v);
            check("abort_fcnt", fail_cnt, fcnt);
            check("abort_fseen", fail_seen, fseen);
            check("abort_ffi", first_fail_idx, ffirst);
            @(negedge clk);
            check("abort_idle", busy, 0);
            check("abort_hold", vec_out, v);
            return;
         end
         if (k == rst_at) begin
            rst_n = 1'b0;
            @(negedge clk);
            rst_n = 1'b1;
            check_reset_vals("midrst");
            @(negedge clk);
            check("midrst_idle", busy, 0);
            return;
         end
         if (k == rst_at - 3) begin
            #1 rst_n = 1'b0;
            #2 rst_n = 1'b1;
         end
         start = noisy && (k == 20 || k == 45);
         if (noisy && k == 30) exp_in = ~EXP_TBL;
         @(negedge clk);
      end
      start  = 1'b0;
      exp_in = EXP_TBL;
      model(stuck, 1000, fcnt, fseen, ffirst);
      check("end_busy", busy, 0);
      check("end_done", done, 1);
      check("end_pass", pass, (fcnt == 0) ? 1 : 0);
      check("end_fcnt", fail_cnt, fcnt);
      check("end_fseen", fail_seen, fseen);
      check("end_ffi", first_fail_idx, ffirst);
      check("end_vec", vec_out, 7);
   endtask

   task automatic sweep_b(input logic stuck);
      int exp_vec[$];
      exp_vec.push_back(0);
      exp_vec.push_back(1);
      stuck_b = stuck;
      start_b = 1'b1;
      @(negedge clk);
      start_b = 1'b0;
      for (int k = 0; k < 2; k++) begin
         check("b_vec", vec_out_b, exp_vec.pop_front());
         check("b_busy", busy_b, 1);
         @(negedge clk);
      end
      check("b_busy_end", busy_b, 0);
      check("b_done", done_b, 1);
      check("b_pass", pass_b, stuck ? 0 : 1);
      check("b_fcnt", fail_cnt_b, stuck ? 1 : 0);
      check("b_fseen", fail_seen_b, stuck ? 1 : 0);
      check("b_ffi", first_fail_idx_b, stuck ? 1 : 0);
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      rst_n       = 1'b0;
      start       = 1'b0;
      abort       = 1'b0;
      stuck0      = 1'b0;
      exp_in      = EXP_TBL;
      start_b     = 1'b0;
      stuck_b     = 1'b0;
      expected_b  = 2'b10;
      repeat (2) @(negedge clk);
      check_reset_vals("reset");
      check("reset_b_busy", busy_b, 0);
      check("reset_b_done", done_b, 0);
      rst_n = 1'b1;
      @(negedge clk);

      sweep(1'b0, -1, -1, 1'b0);   // majority DUT passes
      sweep(1'b1, -1, -1, 1'b0);   // restart from DONE, stuck-at-0 DUT
      sweep(1'b1, 35, -1, 1'b0);   // abort at vector 3
      sweep(1'b1, 59, -1, 1'b0);   // abort coinciding with vector 5 sample
      sweep(1'b0, -1, -1, 1'b1);   // start pulses and expected change mid-run
      sweep(1'b1, -1, 55, 1'b0);   // synchronous reset at vector 5
      sweep_b(1'b0);
      sweep_b(1'b1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
